// File: rtl/apb_master_sequencer_pkg.sv
// apb_ctrl_pkg: shared types for the APB master sequencer.
//   state_e    - sequencer FSM states
//   req_attr_t - width-independent attributes of a captured request
//   idx_width  - index width helper that never collapses to zero bits
package apb_ctrl_pkg;

  localparam int STRB_W = 4;
  localparam int PROT_W = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DECERR = 2'd3
  } state_e;

  typedef struct packed {
    logic              write;
    logic [STRB_W-1:0] strb;
    logic [PROT_W-1:0] prot;
  } req_attr_t;

  // Bits needed to index n items, at least one so single-entry configs still elaborate.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/apb_master_sequencer_if.sv
// apb_if: APB bus bundle between the sequencer (master) and the slaves.
//   master: drives paddr/pwdata/pwrite/penable/pstrb/pprot/psel, samples prdata/pready/pslverr
//   slave : the mirror image
interface apb_if
  import apb_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int SLAVE_NUM  = 8
) ();

  logic [ADDR_WIDTH-1:0] paddr;
  logic [DATA_WIDTH-1:0] pwdata;
  logic                  pwrite;
  logic                  penable;
  logic [STRB_W-1:0]     pstrb;
  logic [PROT_W-1:0]     pprot;
  logic [SLAVE_NUM-1:0]  psel;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  pready;
  logic                  pslverr;

  modport master (
    output paddr, pwdata, pwrite, penable, pstrb, pprot, psel,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  paddr, pwdata, pwrite, penable, pstrb, pprot, psel,
    output prdata, pready, pslverr
  );

endinterface

// File: rtl/apb_master_sequencer_rr_arbiter.sv
// apb_rr_arbiter: round-robin grant among REQ_NUM requesters.
//   clk, rst_n : clock, async active-low reset
//   req        : request vector
//   en         : grants are only issued while en is high
//   gnt        : one-hot grant (combinational)
//   gnt_idx    : index of the granted requester
// The search starts at the pointer and wraps; the pointer moves past the
// winner whenever a grant is issued, so a requester that keeps its request
// up cannot be granted twice while another one is waiting.
module apb_rr_arbiter
  import apb_ctrl_pkg::*;
#(
  parameter  int REQ_NUM = 2,
  localparam int IDX_W   = idx_width(REQ_NUM)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [REQ_NUM-1:0] req,
  input  logic               en,
  output logic [REQ_NUM-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx
);

  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] ptr_d;
  logic             found_s;
  int               slot_s;

  // Grant search: first request at or after the pointer, wrapping around.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found_s = 1'b0;
    slot_s  = 0;
    if (en) begin
      for (int i = 0; i < REQ_NUM; i++) begin
        slot_s = int'(ptr_q) + i;
        if (slot_s >= REQ_NUM) begin
          slot_s = slot_s - REQ_NUM;
        end else begin
          slot_s = slot_s;
        end
        if (!found_s && req[slot_s]) begin
          found_s      = 1'b1;
          gnt[slot_s]  = 1'b1;
          gnt_idx      = IDX_W'(slot_s);
        end else begin
          found_s = found_s;
        end
      end
    end else begin
      found_s = 1'b0;
    end
  end

  // Pointer advance: one past the winner, modulo REQ_NUM.
  always_comb begin
    ptr_d = ptr_q;
    if (found_s) begin
      if (gnt_idx == IDX_W'(REQ_NUM - 1)) begin
        ptr_d = '0;
      end else begin
        ptr_d = gnt_idx + IDX_W'(1);
      end
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/apb_master_sequencer.sv
// apb_master_sequencer: multi-requester APB master.
//   pclk, preset_n : clock, async active-low reset
//   req_*          : packed per-requester request ports; req_ready is the
//                    combinational accept, only ever high in IDLE
//   rsp_*          : one-cycle response pulse to the requester that owned
//                    the transfer (rdata is 0 on writes and errors)
//   apb            : APB master modport (paddr .. pslverr)
// Flow: IDLE (grant + capture) -> SETUP -> ACCESS (until pready or timeout)
// -> IDLE with rsp_valid. Addresses whose slave index field decodes past
// SLAVE_NUM go IDLE -> DECERR -> IDLE and never touch the bus.
module apb_master_sequencer
  import apb_ctrl_pkg::*;
#(
  parameter  int ADDR_WIDTH = 32,
  parameter  int DATA_WIDTH = 32,
  parameter  int SLAVE_NUM  = 8,
  parameter  int REQ_NUM    = 2,
  parameter  int SEL_LSB    = 12,
  parameter  int TIMEOUT    = 16,
  localparam int ID_W       = idx_width(REQ_NUM)
) (
  input  logic                          pclk,
  input  logic                          preset_n,
  input  logic [REQ_NUM-1:0]            req_valid,
  output logic [REQ_NUM-1:0]            req_ready,
  input  logic [REQ_NUM*ADDR_WIDTH-1:0] req_addr,
  input  logic [REQ_NUM*DATA_WIDTH-1:0] req_wdata,
  input  logic [REQ_NUM-1:0]            req_write,
  input  logic [REQ_NUM*STRB_W-1:0]     req_strb,
  input  logic [REQ_NUM*PROT_W-1:0]     req_prot,
  output logic                          rsp_valid,
  output logic [ID_W-1:0]               rsp_id,
  output logic [DATA_WIDTH-1:0]         rsp_rdata,
  output logic                          rsp_err,
  apb_if.master                         apb
);

  localparam int SEL_W = idx_width(SLAVE_NUM);
  localparam int CNT_W = idx_width(TIMEOUT + 1);

  state_e state_q;
  state_e state_d;

  // Captured request; these registers drive the bus fields directly so the
  // address/data phase values stay put through ACCESS and linger in IDLE.
  logic [ADDR_WIDTH-1:0] addr_q,  addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  req_attr_t             attr_q,  attr_d;
  logic [ID_W-1:0]       id_q,    id_d;
  logic [SLAVE_NUM-1:0]  psel_q,  psel_d;
  logic                  penable_q, penable_d;
  logic [CNT_W-1:0]      wait_cnt_q, wait_cnt_d;

  logic                  rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]       rsp_id_q,    rsp_id_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q,   rsp_err_d;

  logic [REQ_NUM-1:0]    gnt_s;
  logic [ID_W-1:0]       gnt_idx_s;
  logic                  hs_s;
  logic [ADDR_WIDTH-1:0] sel_addr_s;
  logic [DATA_WIDTH-1:0] sel_wdata_s;
  req_attr_t             sel_attr_s;
  logic [SEL_W-1:0]      sel_idx_s;
  logic                  decerr_s;
  logic                  timeout_s;

  apb_rr_arbiter #(.REQ_NUM(REQ_NUM)) u_arb (
    .clk     (pclk),
    .rst_n   (preset_n),
    .req     (req_valid),
    .en      (state_q == IDLE),
    .gnt     (gnt_s),
    .gnt_idx (gnt_idx_s)
  );

  assign req_ready = gnt_s;
  assign hs_s      = |gnt_s;

  // Select the granted requester's fields and decode its slave index.
  always_comb begin
    sel_addr_s       = req_addr[int'(gnt_idx_s)*ADDR_WIDTH +: ADDR_WIDTH];
    sel_wdata_s      = req_wdata[int'(gnt_idx_s)*DATA_WIDTH +: DATA_WIDTH];
    sel_attr_s.write = req_write[gnt_idx_s];
    sel_attr_s.prot  = req_prot[int'(gnt_idx_s)*PROT_W +: PROT_W];
    // Reads never present strobes on the bus.
    if (req_write[gnt_idx_s]) begin
      sel_attr_s.strb = req_strb[int'(gnt_idx_s)*STRB_W +: STRB_W];
    end else begin
      sel_attr_s.strb = {STRB_W{1'b0}};
    end
    sel_idx_s = sel_addr_s[SEL_LSB +: SEL_W];
    decerr_s  = (int'(sel_idx_s) >= SLAVE_NUM);
  end

  // The abort fires on the last permitted wait cycle, so TIMEOUT ACCESS cycles in total.
  assign timeout_s = (TIMEOUT != 0) && (wait_cnt_q == CNT_W'(TIMEOUT - 1)) && !apb.pready;

  // FSM state register.
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (hs_s) begin
          state_d = decerr_s ? DECERR : SETUP;
        end else begin
          state_d = IDLE;
        end
      end
      SETUP:  state_d = ACCESS;
      ACCESS: begin
        if (apb.pready || timeout_s) begin
          state_d = IDLE;
        end else begin
          state_d = ACCESS;
        end
      end
      DECERR:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM output logic: bus phase controls, capture, wait counter and response.
  always_comb begin
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    attr_d      = attr_q;
    id_d        = id_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    wait_cnt_d  = wait_cnt_q;
    rsp_valid_d = 1'b0;
    rsp_id_d    = {ID_W{1'b0}};
    rsp_rdata_d = {DATA_WIDTH{1'b0}};
    rsp_err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        psel_d     = {SLAVE_NUM{1'b0}};
        penable_d  = 1'b0;
        wait_cnt_d = {CNT_W{1'b0}};
        if (hs_s) begin
          addr_d  = sel_addr_s;
          wdata_d = sel_wdata_s;
          attr_d  = sel_attr_s;
          id_d    = gnt_idx_s;
          if (!decerr_s) begin
            psel_d = {{(SLAVE_NUM-1){1'b0}}, 1'b1} << sel_idx_s;
          end else begin
            psel_d = {SLAVE_NUM{1'b0}};
          end
        end else begin
          addr_d = addr_q;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
      end
      ACCESS: begin
        if (apb.pready) begin
          psel_d      = {SLAVE_NUM{1'b0}};
          penable_d   = 1'b0;
          wait_cnt_d  = {CNT_W{1'b0}};
          rsp_valid_d = 1'b1;
          rsp_id_d    = id_q;
          rsp_err_d   = apb.pslverr;
          rsp_rdata_d = (attr_q.write || apb.pslverr) ? {DATA_WIDTH{1'b0}} : apb.prdata;
        end else if (timeout_s) begin
          psel_d      = {SLAVE_NUM{1'b0}};
          penable_d   = 1'b0;
          wait_cnt_d  = {CNT_W{1'b0}};
          rsp_valid_d = 1'b1;
          rsp_id_d    = id_q;
          rsp_err_d   = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end
      DECERR: begin
        rsp_valid_d = 1'b1;
        rsp_id_d    = id_q;
        rsp_err_d   = 1'b1;
      end
      default: begin
        psel_d    = {SLAVE_NUM{1'b0}};
        penable_d = 1'b0;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      addr_q      <= '0;
      wdata_q     <= '0;
      attr_q      <= '0;
      id_q        <= '0;
      psel_q      <= '0;
      penable_q   <= 1'b0;
      wait_cnt_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      attr_q      <= attr_d;
      id_q        <= id_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      wait_cnt_q  <= wait_cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign apb.paddr   = addr_q;
  assign apb.pwdata  = wdata_q;
  assign apb.pwrite  = attr_q.write;
  assign apb.pstrb   = attr_q.strb;
  assign apb.pprot   = attr_q.prot;
  assign apb.psel    = psel_q;
  assign apb.penable = penable_q;

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_master_sequencer.sv
// Directed bench for apb_master_sequencer. The main instance uses the default
// 8-slave map; a second instance with 6 slaves covers the decode error path.
module tb_apb_master_sequencer;

  logic        pclk = 1'b0;
  logic        preset_n = 1'b0;
  logic [1:0]  req_valid, req_ready, req_valid_b, req_ready_b, req_write;
  logic [63:0] req_addr, req_wdata;
  logic [7:0]  req_strb;
  logic [5:0]  req_prot;
  logic        rsp_valid, rsp_err, rsp_valid_b, rsp_err_b;
  logic [0:0]  rsp_id, rsp_id_b;
  logic [31:0] rsp_rdata, rsp_rdata_b;
  int          total = 0;
  int          bad = 0;

  apb_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .SLAVE_NUM(8)) bus ();
  apb_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .SLAVE_NUM(6)) bus_b ();

  apb_master_sequencer #(.SLAVE_NUM(8)) u_dut (
    .pclk(pclk), .preset_n(preset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_write(req_write), .req_strb(req_strb),
    .req_prot(req_prot), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .apb(bus)
  );

  apb_master_sequencer #(.SLAVE_NUM(6)) u_dut_b (
    .pclk(pclk), .preset_n(preset_n), .req_valid(req_valid_b), .req_ready(req_ready_b),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_write(req_write), .req_strb(req_strb),
    .req_prot(req_prot), .rsp_valid(rsp_valid_b), .rsp_id(rsp_id_b), .rsp_rdata(rsp_rdata_b),
    .rsp_err(rsp_err_b), .apb(bus_b)
  );

  always #5 pclk = ~pclk;

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  task automatic set_req(input int r, input logic [31:0] a, input logic [31:0] d,
                         input logic w, input logic [3:0] s, input logic [2:0] p);
    req_addr[r*32 +: 32]  = a;
    req_wdata[r*32 +: 32] = d;
    req_write[r]          = w;
    req_strb[r*4 +: 4]    = s;
    req_prot[r*3 +: 3]    = p;
  endtask

  task automatic test_reset();
    req_valid = 2'b00; req_valid_b = 2'b00; req_write = 2'b00;
    req_addr = '0; req_wdata = '0; req_strb = '0; req_prot = '0;
    bus.prdata = 32'h0; bus.pready = 1'b0; bus.pslverr = 1'b0;
    bus_b.prdata = 32'h0; bus_b.pready = 1'b1; bus_b.pslverr = 1'b0;
    preset_n = 1'b0;
    #12;
    total++; if ({bus.paddr, bus.pwdata, bus.pwrite, bus.penable, bus.pstrb, bus.pprot, bus.psel} !== 84'h0) begin bad++; $display("FAIL rst_bus: got %h exp 0", {bus.paddr, bus.pwdata, bus.pwrite, bus.penable, bus.pstrb, bus.pprot, bus.psel}); end
    total++; if ({rsp_valid, rsp_id, rsp_rdata, rsp_err, req_ready} !== 37'h0) begin bad++; $display("FAIL rst_rsp: got %h exp 0", {rsp_valid, rsp_id, rsp_rdata, rsp_err, req_ready}); end
    @(negedge pclk);
    preset_n = 1'b1;
    step();
  endtask

  task automatic test_single_write();
    set_req(0, 32'h0000_2004, 32'hDEAD_BEEF, 1'b1, 4'hF, 3'b001);
    bus.pready = 1'b1; bus.pslverr = 1'b0; bus.prdata = 32'h0;
    req_valid = 2'b01;
    #1;
    total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL wr_ready: got %b exp 01", req_ready); end
    step(); // SETUP
    total++; if (req_ready !== 2'b00) begin bad++; $display("FAIL wr_ready_setup: got %b exp 00", req_ready); end
    req_valid = 2'b00;
    total++; if ({bus.psel, bus.penable} !== {8'h04, 1'b0}) begin bad++; $display("FAIL wr_setup: got %h/%b exp 04/0", bus.psel, bus.penable); end
    total++; if ({bus.paddr, bus.pwdata, bus.pwrite, bus.pstrb, bus.pprot} !== {32'h0000_2004, 32'hDEAD_BEEF, 1'b1, 4'hF, 3'b001}) begin bad++; $display("FAIL wr_fields: got %h %h %b %h %b", bus.paddr, bus.pwdata, bus.pwrite, bus.pstrb, bus.pprot); end
    step(); // ACCESS
    total++; if ({bus.psel, bus.penable, rsp_valid} !== {8'h04, 1'b1, 1'b0}) begin bad++; $display("FAIL wr_access: got %h/%b/%b exp 04/1/0", bus.psel, bus.penable, rsp_valid); end
    step(); // IDLE with response
    total++; if ({rsp_valid, rsp_err, rsp_rdata, rsp_id} !== {1'b1, 1'b0, 32'h0, 1'b0}) begin bad++; $display("FAIL wr_rsp: got v=%b e=%b d=%h id=%b exp 1 0 0 0", rsp_valid, rsp_err, rsp_rdata, rsp_id); end
    total++; if ({bus.psel, bus.penable} !== 9'h0) begin bad++; $display("FAIL wr_idle_bus: got %h/%b exp 0", bus.psel, bus.penable); end
    step();
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL wr_pulse: got %b exp 0", rsp_valid); end
  endtask

  task automatic test_read_wait();
    set_req(1, 32'h0000_7010, 32'h55AA_55AA, 1'b0, 4'hF, 3'b010);
    bus.pready = 1'b0; bus.prdata = 32'hFFFF_FFFF;
    req_valid = 2'b10;
    #1;
    total++; if (req_ready !== 2'b10) begin bad++; $display("FAIL rd_ready: got %b exp 10", req_ready); end
    step(); // SETUP
    req_valid = 2'b00;
    total++; if ({bus.psel, bus.penable, bus.pwrite, bus.pstrb} !== {8'h80, 1'b0, 1'b0, 4'h0}) begin bad++; $display("FAIL rd_setup: got %h %b %b %h", bus.psel, bus.penable, bus.pwrite, bus.pstrb); end
    for (int k = 1; k <= 4; k++) begin
      step(); // ACCESS k
      total++; if ({bus.psel, bus.penable, bus.paddr, bus.pstrb, bus.pwrite, bus.pprot, rsp_valid} !== {8'h80, 1'b1, 32'h0000_7010, 4'h0, 1'b0, 3'b010, 1'b0}) begin bad++; $display("FAIL rd_stable%0d: got %h %b %h %h %b %b %b", k, bus.psel, bus.penable, bus.paddr, bus.pstrb, bus.pwrite, bus.pprot, rsp_valid); end
      bus.pready = (k == 4);
      bus.prdata = (k == 4) ? 32'h1234_5678 : 32'hFFFF_FFFF;
    end
    step();
    total++; if ({rsp_valid, rsp_err, rsp_rdata, rsp_id} !== {1'b1, 1'b0, 32'h1234_5678, 1'b1}) begin bad++; $display("FAIL rd_rsp: got v=%b e=%b d=%h id=%b exp 1 0 12345678 1", rsp_valid, rsp_err, rsp_rdata, rsp_id); end
    bus.prdata = 32'h0;
  endtask

  task automatic test_round_robin();
    logic [1:0] order [4];
    int         at [4];
    int         n = 0;
    preset_n = 1'b0;
    #1;
    preset_n = 1'b1;
    set_req(0, 32'h0000_1000, 32'h0000_0011, 1'b1, 4'hF, 3'b000);
    set_req(1, 32'h0000_3000, 32'h0000_0022, 1'b1, 4'hF, 3'b000);
    bus.pready = 1'b1;
    req_valid = 2'b11;
    #1;
    for (int c = 0; c < 30 && n < 4; c++) begin
      if (req_ready !== 2'b00) begin
        order[n] = req_ready;
        at[n]    = c;
        n++;
      end
      step();
    end
    req_valid = 2'b00;
    total++; if (n !== 4) begin bad++; $display("FAIL rr_count: got %0d exp 4", n); end
    for (int i = 0; i < n; i++) begin
      total++; if (order[i] !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin bad++; $display("FAIL rr_order%0d: got %b exp %b", i, order[i], (i % 2 == 0) ? 2'b01 : 2'b10); end
    end
    for (int i = 1; i < n; i++) begin
      total++; if (at[i] - at[i-1] !== 3) begin bad++; $display("FAIL rr_gap%0d: got %0d exp 3", i, at[i] - at[i-1]); end
    end
    repeat (3) step();
  endtask

  task automatic test_decode_error();
    set_req(0, 32'h0000_7000, 32'h0, 1'b0, 4'h0, 3'b000);
    req_valid_b = 2'b01;
    #1;
    total++; if (req_ready_b !== 2'b01) begin bad++; $display("FAIL de_ready: got %b exp 01", req_ready_b); end
    step(); // DECERR
    req_valid_b = 2'b00;
    total++; if ({bus_b.psel, bus_b.penable, rsp_valid_b} !== 8'h0) begin bad++; $display("FAIL de_nobus: got %h %b %b exp 0", bus_b.psel, bus_b.penable, rsp_valid_b); end
    step(); // IDLE with error response
    total++; if ({rsp_valid_b, rsp_err_b, rsp_rdata_b, bus_b.psel} !== {1'b1, 1'b1, 32'h0, 6'h0}) begin bad++; $display("FAIL de_rsp: got v=%b e=%b d=%h psel=%h", rsp_valid_b, rsp_err_b, rsp_rdata_b, bus_b.psel); end
    // Highest valid index on the 6-slave map still decodes normally.
    set_req(0, 32'h0000_5000, 32'h0, 1'b0, 4'h0, 3'b000);
    req_valid_b = 2'b01;
    step(); // SETUP
    req_valid_b = 2'b00;
    total++; if (bus_b.psel !== 6'h20) begin bad++; $display("FAIL de_edge_psel: got %h exp 20", bus_b.psel); end
    step();
    step();
    total++; if ({rsp_valid_b, rsp_err_b} !== 2'b10) begin bad++; $display("FAIL de_edge_rsp: got %b%b exp 10", rsp_valid_b, rsp_err_b); end
  endtask

  task automatic test_timeout();
    int cnt = 0;
    set_req(0, 32'h0000_4000, 32'h0, 1'b0, 4'hF, 3'b000);
    bus.pready = 1'b0; bus.prdata = 32'hAAAA_5555;
    req_valid = 2'b01;
    step(); // SETUP
    req_valid = 2'b00;
    total++; if (bus.psel !== 8'h10) begin bad++; $display("FAIL to_psel: got %h exp 10", bus.psel); end
    for (int c = 0; c < 40; c++) begin
      step();
      if (bus.penable) cnt++;
      else break;
    end
    total++; if (cnt !== 16) begin bad++; $display("FAIL to_cycles: got %0d exp 16", cnt); end
    total++; if ({rsp_valid, rsp_err, rsp_rdata, rsp_id, bus.psel} !== {1'b1, 1'b1, 32'h0, 1'b0, 8'h0}) begin bad++; $display("FAIL to_rsp: got v=%b e=%b d=%h id=%b psel=%h", rsp_valid, rsp_err, rsp_rdata, rsp_id, bus.psel); end
    set_req(1, 32'h0000_1000, 32'h0BAD_CAFE, 1'b1, 4'h3, 3'b000);
    bus.pready = 1'b1;
    req_valid = 2'b10;
    #1;
    total++; if (req_ready !== 2'b10) begin bad++; $display("FAIL to_next_ready: got %b exp 10", req_ready); end
    step();
    req_valid = 2'b00;
    total++; if ({bus.psel, bus.pstrb} !== {8'h02, 4'h3}) begin bad++; $display("FAIL to_next_setup: got %h %h exp 02 3", bus.psel, bus.pstrb); end
    step();
    step();
    total++; if ({rsp_valid, rsp_err, rsp_id} !== 3'b101) begin bad++; $display("FAIL to_next_rsp: got %b%b%b exp 101", rsp_valid, rsp_err, rsp_id); end
  endtask

  task automatic test_slave_error();
    set_req(0, 32'h0000_6000, 32'h0000_0001, 1'b1, 4'hF, 3'b000);
    bus.pready = 1'b1; bus.pslverr = 1'b1;
    req_valid = 2'b01;
    step();
    req_valid = 2'b00;
    total++; if (bus.psel !== 8'h40) begin bad++; $display("FAIL se_psel: got %h exp 40", bus.psel); end
    step();
    step();
    total++; if ({rsp_valid, rsp_err, rsp_id} !== 3'b110) begin bad++; $display("FAIL se_rsp: got %b%b%b exp 110", rsp_valid, rsp_err, rsp_id); end
    // pslverr while pready is low must not count.
    set_req(1, 32'h0000_2000, 32'h0, 1'b0, 4'h0, 3'b000);
    bus.pready = 1'b0; bus.pslverr = 1'b1;
    req_valid = 2'b10;
    step(); // SETUP
    req_valid = 2'b00;
    step(); // ACCESS 1
    step(); // ACCESS 2
    total++; if ({bus.penable, rsp_valid} !== 2'b10) begin bad++; $display("FAIL se_wait: got %b%b exp 10", bus.penable, rsp_valid); end
    bus.pready = 1'b1; bus.pslverr = 1'b0; bus.prdata = 32'hCAFE_F00D;
    step();
    total++; if ({rsp_valid, rsp_err, rsp_rdata, rsp_id} !== {1'b1, 1'b0, 32'hCAFE_F00D, 1'b1}) begin bad++; $display("FAIL se_ignore: got v=%b e=%b d=%h id=%b", rsp_valid, rsp_err, rsp_rdata, rsp_id); end
  endtask

  task automatic test_reset_abort();
    set_req(0, 32'h0000_3000, 32'h0000_00FF, 1'b1, 4'hF, 3'b000);
    bus.pready = 1'b0;
    req_valid = 2'b01;
    step(); // SETUP
    req_valid = 2'b00;
    step(); // ACCESS
    total++; if ({bus.psel, bus.penable} !== {8'h08, 1'b1}) begin bad++; $display("FAIL ra_access: got %h/%b exp 08/1", bus.psel, bus.penable); end
    #2;
    preset_n = 1'b0;
    #1;
    total++; if ({bus.psel, bus.penable, rsp_valid, bus.paddr} !== 42'h0) begin bad++; $display("FAIL ra_async: got %h/%b/%b/%h exp 0", bus.psel, bus.penable, rsp_valid, bus.paddr); end
    #10;
    @(negedge pclk);
    preset_n = 1'b1;
    bus.pready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      total++; if ({rsp_valid, bus.psel} !== 9'h0) begin bad++; $display("FAIL ra_quiet%0d: got %b/%h exp 0", c, rsp_valid, bus.psel); end
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_read_wait();
    test_round_robin();
    test_decode_error();
    test_timeout();
    test_slave_error();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
